// File: rtl/upmixer_dsm_2b_if.sv
// Signal bundle for the 5-level transmit upmixer: baseband/NCO samples in, RF code and flags out.
// The driver (bench or upstream block) takes the master view; the upmixer takes the slave view.
interface upmixer_dsm_2b_if #(
    parameter int unsigned BITS = 16
);
    logic                   TX_EN;
    logic signed [BITS-1:0] I_in;
    logic signed [BITS-1:0] Q_in;
    logic signed [BITS-1:0] sin_in;
    logic signed [BITS-1:0] cos_in;
    logic                   CLIP_CLR;
    logic [2:0]             RF_code;
    logic                   RF_bit;
    logic                   CLIP;

    modport master (
        output TX_EN, I_in, Q_in, sin_in, cos_in, CLIP_CLR,
        input  RF_code, RF_bit, CLIP
    );

    modport slave (
        input  TX_EN, I_in, Q_in, sin_in, cos_in, CLIP_CLR,
        output RF_code, RF_bit, CLIP
    );
endinterface

// File: rtl/upmixer_dsm_2b.sv
// Transmit upmixer: x = I*cos + Q*sin, re-quantised to a 5-level RF code by a
// first-order error-feedback delta-sigma loop. Four free-running register stages.
module upmixer_dsm_2b #(
    parameter int unsigned BITS = 16
) (
    input  logic             CLK,
    input  logic             RST,
    upmixer_dsm_2b_if.slave  bus
);
    localparam int unsigned W = BITS + 4;

    localparam logic signed [W-1:0] QV   = W'(1) << (BITS - 2);
    localparam logic signed [W-1:0] HV   = W'(1) << (BITS - 3);
    localparam logic signed [W-1:0] Q2V  = QV + QV;
    localparam logic signed [W-1:0] H3V  = QV + HV;
    localparam logic signed [W-1:0] NHV  = -HV;
    localparam logic signed [W-1:0] NH3V = -H3V;
    localparam logic signed [W-1:0] EMAX = (W'(1) << (BITS - 1)) - W'(1);
    localparam logic signed [W-1:0] EMIN = -(W'(1) << (BITS - 1));

    // S1
    logic signed [BITS-1:0]   i_r, q_r, s_r, c_r;
    // S2
    logic signed [2*BITS-1:0] pi_r, pq_r;
    logic signed [2*BITS-1:0] i_w, q_w, s_w, c_w;
    // S3
    logic signed [2*BITS:0]   psum;
    logic signed [BITS+1:0]   x_r;
    logic signed [BITS+1:0]   x_next;
    // S4
    logic signed [BITS-1:0]   e_r;
    logic [2:0]               code_r;
    logic                     bit_r;
    logic                     clip_r;

    logic signed [W-1:0]      x_w, e_w, v, ne;
    logic [2:0]               k;
    logic                     sat;
    logic signed [BITS-1:0]   e_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            i_r  <= '0;
            q_r  <= '0;
            s_r  <= '0;
            c_r  <= '0;
            pi_r <= '0;
            pq_r <= '0;
            x_r  <= '0;
        end else begin
            i_r  <= bus.I_in;
            q_r  <= bus.Q_in;
            s_r  <= bus.sin_in;
            c_r  <= bus.cos_in;
            pi_r <= i_w * c_w;
            pq_r <= q_w * s_w;
            x_r  <= x_next;
        end
    end

    always_comb begin
        i_w    = {{BITS{i_r[BITS-1]}}, i_r};
        q_w    = {{BITS{q_r[BITS-1]}}, q_r};
        s_w    = {{BITS{s_r[BITS-1]}}, s_r};
        c_w    = {{BITS{c_r[BITS-1]}}, c_r};
        psum   = {pi_r[2*BITS-1], pi_r} + {pq_r[2*BITS-1], pq_r};
        // Keeping the top BITS+2 bits is the floor shift by BITS-1.
        x_next = psum[2*BITS:BITS-1];
    end

    always_comb begin
        x_w    = {{2{x_r[BITS+1]}}, x_r};
        e_w    = {{4{e_r[BITS-1]}}, e_r};
        v      = x_w + e_w;
        k      = 3'd2;
        ne     = v;
        sat    = 1'b0;
        e_next = '0;
        // Thresholds sit at odd multiples of H; equality falls into the upper bin.
        if (v < NH3V) begin
            k  = 3'd0;
            ne = v + Q2V;
        end else if (v < NHV) begin
            k  = 3'd1;
            ne = v + QV;
        end else if (v < HV) begin
            k  = 3'd2;
            ne = v;
        end else if (v < H3V) begin
            k  = 3'd3;
            ne = v - QV;
        end else begin
            k  = 3'd4;
            ne = v - Q2V;
        end
        if (ne > EMAX) begin
            sat    = 1'b1;
            e_next = EMAX[BITS-1:0];
        end else if (ne < EMIN) begin
            sat    = 1'b1;
            e_next = EMIN[BITS-1:0];
        end else begin
            e_next = ne[BITS-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            e_r    <= '0;
            code_r <= 3'd2;
            bit_r  <= 1'b1;
            clip_r <= 1'b0;
        end else begin
            if (bus.TX_EN) begin
                e_r    <= e_next;
                code_r <= k;
                bit_r  <= (k >= 3'd2);
            end else begin
                e_r    <= '0;
                code_r <= 3'd2;
                bit_r  <= 1'b1;
            end
            if (bus.TX_EN && sat)
                clip_r <= 1'b1;
            else if (bus.CLIP_CLR)
                clip_r <= 1'b0;
        end
    end

    assign bus.RF_code = code_r;
    assign bus.RF_bit  = bit_r;
    assign bus.CLIP    = clip_r;
endmodule

// File: tb/tb_upmixer_dsm_2b.sv
// Bench for upmixer_dsm_2b: expected x values are queued at drive time and
// run through a reference quantiser when they reach the output stage.
module tb_upmixer_dsm_2b;
    localparam int unsigned BITS = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    upmixer_dsm_2b_if #(.BITS(BITS)) bus ();
    upmixer_dsm_2b #(.BITS(BITS)) dut (.CLK(clk), .RST(rst), .bus(bus));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    longint x_q[$];
    longint m_e;
    int     m_code;
    bit     m_bit;
    bit     m_clip;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint ref_x(input int i, input int q, input int s, input int c);
        longint p;
        p = longint'(i) * longint'(c) + longint'(q) * longint'(s);
        return p >>> (BITS - 1);
    endfunction

    task automatic model_reset();
        x_q    = {};
        repeat (3) x_q.push_back(0);
        m_e    = 0;
        m_code = 2;
        m_bit  = 1'b1;
        m_clip = 1'b0;
    endtask

    task automatic model_edge(input longint xv, input bit en, input bit clr);
        longint qc, h, v, ne, emax, emin;
        int     k;
        bit     sat;
        qc   = longint'(1) << (BITS - 2);
        h    = longint'(1) << (BITS - 3);
        emax = (longint'(1) << (BITS - 1)) - 1;
        emin = -(longint'(1) << (BITS - 1));
        sat  = 1'b0;
        if (en) begin
            v = xv + m_e;
            if (v < -3 * h)      k = 0;
            else if (v < -h)     k = 1;
            else if (v < h)      k = 2;
            else if (v < 3 * h)  k = 3;
            else                 k = 4;
            ne = v - longint'(k - 2) * qc;
            if (ne > emax) begin ne = emax; sat = 1'b1; end
            else if (ne < emin) begin ne = emin; sat = 1'b1; end
            m_e    = ne;
            m_code = k;
            m_bit  = (k >= 2);
        end else begin
            m_e    = 0;
            m_code = 2;
            m_bit  = 1'b1;
        end
        if (sat)      m_clip = 1'b1;
        else if (clr) m_clip = 1'b0;
    endtask

    // Called just after an active edge: drives, waits one clock, then compares.
    task automatic step(input int i, input int q, input int s, input int c,
                        input bit en, input bit clr);
        longint xv;
        bus.I_in     = i[BITS-1:0];
        bus.Q_in     = q[BITS-1:0];
        bus.sin_in   = s[BITS-1:0];
        bus.cos_in   = c[BITS-1:0];
        bus.TX_EN    = en;
        bus.CLIP_CLR = clr;
        x_q.push_back(ref_x(i, q, s, c));
        @(posedge clk);
        #1;
        xv = x_q.pop_front();
        model_edge(xv, en, clr);
        check("RF_code", bus.RF_code, m_code);
        check("RF_bit",  bus.RF_bit,  m_bit);
        check("CLIP",    bus.CLIP,    m_clip);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int run;
        bit done;

        rst          = 1'b1;
        bus.TX_EN    = 1'b1;
        bus.I_in     = '0;
        bus.Q_in     = '0;
        bus.sin_in   = '0;
        bus.cos_in   = '0;
        bus.CLIP_CLR = 1'b0;

        // Async reset takes effect before the first clock edge.
        #2;
        check("rst_code", bus.RF_code, 2);
        check("rst_bit",  bus.RF_bit,  1);
        check("rst_clip", bus.CLIP,    0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Zeros with arbitrary NCO values
        for (int n = 0; n < 10; n++)
            step(0, 0, int'($urandom_range(65535)) - 32768,
                 int'($urandom_range(65535)) - 32768, 1'b1, 1'b0);

        // Half level, then a 3-clock enable gap and re-enable
        for (int n = 0; n < 12; n++) step(16384, 0, 0, 16384, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++)  step(16384, 0, 0, 16384, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++)  step(16384, 0, 0, 16384, 1'b1, 1'b0);

        // Near full scale: hold disabled while the pipeline fills, then count 4s
        for (int n = 0; n < 4; n++) step(32767, 0, 0, 32767, 1'b0, 1'b0);
        run  = 0;
        done = 1'b0;
        for (int n = 0; n < 4110; n++) begin
            step(32767, 0, 0, 32767, 1'b1, 1'b0);
            if (!done) begin
                if (bus.RF_code == 3'd4) run++;
                else done = 1'b1;
            end
        end
        check("run_of_4", run, 4096);
        check("after_run_code", bus.RF_code, 4);

        // Clip: all four inputs at most-negative value
        for (int n = 0; n < 8; n++) step(-32768, -32768, -32768, -32768, 1'b1, 1'b0);
        check("clip_set", bus.CLIP, 1);
        for (int n = 0; n < 4; n++) step(-32768, -32768, -32768, -32768, 1'b1, 1'b1);
        check("clip_held", bus.CLIP, 1);
        for (int n = 0; n < 8; n++) step(0, 0, 0, 0, 1'b1, 1'b1);
        check("clip_cleared", bus.CLIP, 0);
        for (int n = 0; n < 6; n++) step(0, 0, 0, 0, 1'b1, 1'b0);

        // Mid-stream async reset between edges
        for (int n = 0; n < 9; n++) step(16384, 0, 0, 16384, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_code", bus.RF_code, 2);
        check("arst_bit",  bus.RF_bit,  1);
        check("arst_clip", bus.CLIP,    0);
        #1;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 4; n++) begin
            step(0, 0, 0, 0, 1'b1, 1'b0);
            check("post_rst_code", bus.RF_code, 2);
        end

        // Short mixed I/Q run to exercise the Q*sin path and negative bins
        for (int n = 0; n < 20; n++)
            step(-20000, 12000, -9000 + n * 700, 15000 - n * 900, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) step(0, 0, 0, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
